// File: rtl/apb_initiator.sv
// rtl/apb_initiator.sv - core-side APB4 initiator, one outstanding transfer, valid/ready request/response
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_initiator #(
  parameter int ADDR_W         = 34,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  input  logic              pready,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [31:0]       pwdata,
  output logic [3:0]        pwstrb,
  input  logic [31:0]       prdata,
  input  logic              pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) < 8) ? 8 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] to_cnt;
`endif

  // The bus registers double as the request latches; they only load on aligned requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      pwstrb    <= '0;
`ifdef APB_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (req_addr[1:0] != 2'b00) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state     <= RESP;
            end else begin
              paddr  <= req_addr;
              pwrite <= req_write;
              pwdata <= req_wdata;
              pwstrb <= req_write ? req_wstrb : 4'b0000;
              psel   <= 1'b1;
              state  <= SETUP;
            end
          end
        end
        SETUP: begin
          penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
          to_cnt  <= '0;
`endif
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= pslverr;
            rsp_rdata <= (!pwrite && !pslverr) ? prdata : 32'h0;
            state     <= RESP;
          end
`ifdef APB_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'h0;
            state     <= RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_initiator.sv
// tb/tb_apb_initiator.sv - scoreboard bench for apb_initiator (timeout cases under APB_TIMEOUT_EN)
module tb_apb_initiator;

  localparam int ADDR_W = 34;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              req_write = 1'b0;
  logic [31:0]       req_wdata = '0;
  logic [3:0]        req_wstrb = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              psel;
  logic              penable;
  logic              pready = 1'b0;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [31:0]       pwdata;
  logic [3:0]        pwstrb;
  logic [31:0]       prdata = '0;
  logic              pslverr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];

  apb_initiator #(
    .ADDR_W(ADDR_W),
`ifdef APB_TIMEOUT_EN
    .TIMEOUT_CYCLES(8)
`else
    .TIMEOUT_CYCLES(256)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pready(pready), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .pwstrb(pwstrb), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: compares each response handshake against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("rsp_rdata", 64'(rsp_rdata), 64'(e[31:0]));
        check("rsp_err", 64'(rsp_err), 64'(e[32]));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", 64'(req_ready), 64'd1);
  endtask

  task automatic issue(input logic [ADDR_W-1:0] addr, input logic wr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = addr; req_write = wr; req_wdata = wdata; req_wstrb = wstrb;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = '1; req_wdata = 32'hFFFF_FFFF; req_wstrb = 4'hF; req_write = ~wr;
  endtask

  // Full aligned transfer with `waits` pready-low ACCESS cycles.
  task automatic xfer(input logic [ADDR_W-1:0] addr, input logic wr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, input int waits, input logic [31:0] rdata,
                      input logic slverr, input logic [31:0] exp_rdata, input logic exp_err);
    exp_q.push_back({exp_err, exp_rdata});
    issue(addr, wr, wdata, wstrb);
    @(negedge clk);
    check("setup_psel", 64'(psel), 64'd1);
    check("setup_penable", 64'(penable), 64'd0);
    for (int i = 0; i <= waits; i++) begin
      @(posedge clk); #1;
      pready = (i == waits); prdata = rdata; pslverr = slverr;
      @(negedge clk);
      check("access_psel", 64'(psel), 64'd1);
      check("access_penable", 64'(penable), 64'd1);
      check("access_paddr", 64'(paddr), 64'(addr));
      check("access_pwrite", 64'(pwrite), 64'(wr));
      check("access_pwdata", 64'(pwdata), 64'(wdata));
      check("access_pwstrb", 64'(pwstrb), 64'(wr ? wstrb : 4'b0000));
    end
    @(posedge clk); #1;
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h0BAD_0BAD;
    check("rsp_latency", 64'(rsp_valid), 64'd1);
    check("resp_psel", 64'({psel, penable}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    #12;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_bus", 64'({psel, penable, rsp_valid}), 64'd0);
    check("rst_paddr", 64'(paddr), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    wait_idle();

    xfer(34'h0_0000_1000, 1'b0, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0);
    wait_idle();
    xfer(34'h0_8000_0004, 1'b1, 32'h55, 4'b0001, 3, 32'h1111_2222, 1'b0, 32'h0, 1'b0);
    wait_idle();
    xfer(34'h2_0000_0000, 1'b0, 32'h0, 4'h0, 0, 32'h1234, 1'b1, 32'h0, 1'b1);
    wait_idle();
    xfer(34'h0_0000_0010, 1'b1, 32'hA5A5_5A5A, 4'b1100, 1, 32'h7777, 1'b1, 32'h0, 1'b1);
    wait_idle();

    // Misaligned: error response, bus never selected.
    exp_q.push_back({1'b1, 32'h0});
    issue(34'h0_0000_0002, 1'b0, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("misalign_psel", 64'(psel), 64'd0);
    end
    wait_idle();

    // Backpressure: response held while rsp_ready is low.
    rsp_ready = 1'b0;
    xfer(34'h0_0000_0040, 1'b0, 32'h0, 4'h0, 1, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check("bp_rsp_rdata", 64'(rsp_rdata), 64'hCAFE_F00D);
      check("bp_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_idle();

    // Reset during ACCESS drops the transfer with no response.
    issue(34'h0_0000_0100, 1'b0, 32'h0, 4'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_penable", 64'(penable), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_bus", 64'({psel, penable, rsp_valid}), 64'd0);
    check("rst_async_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    wait_idle();
    xfer(34'h0_0000_0200, 1'b0, 32'h0, 4'h0, 0, 32'h0123_4567, 1'b0, 32'h0123_4567, 1'b0);
    wait_idle();

`ifdef APB_TIMEOUT_EN
    // pready stuck low: timeout after 8 ACCESS cycles.
    exp_q.push_back({1'b1, 32'h0});
    issue(34'h0_0000_0300, 1'b0, 32'h0, 4'h0);
    prdata = 32'h9999_9999;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("to_access_psel", 64'({psel, penable}), 64'd3);
    end
    @(posedge clk); #1;
    check("to_psel_drop", 64'({psel, penable}), 64'd0);
    check("to_rsp_valid", 64'(rsp_valid), 64'd1);
    wait_idle();
    // pready on the 8th ACCESS cycle wins over the timeout.
    xfer(34'h0_0000_0304, 1'b0, 32'h0, 4'h0, 7, 32'h8888_0001, 1'b0, 32'h8888_0001, 1'b0);
    wait_idle();
    xfer(34'h0_0000_0308, 1'b0, 32'h0, 4'h0, 7, 32'h8888_0002, 1'b1, 32'h0, 1'b1);
    wait_idle();
`endif

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
